// File: rtl/ee201_pb_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: one-hot state encoding,
// registered output bundle, and timing-window derivation from the counter width.
package ee201_pb_debouncer_pkg;

  typedef enum logic [6:0] {
    INI     = 7'b0000001,
    WQ      = 7'b0000010,
    SCEN_ST = 7'b0000100,
    WH      = 7'b0001000,
    MCEN_ST = 7'b0010000,
    CCR     = 7'b0100000,
    WFCR    = 7'b1000000
  } state_e;

  typedef struct packed {
    logic dpb;
    logic scen;
    logic mcen;
    logic ccen;
  } pb_out_t;

  // Stable window used both for press qualification and clean release.
  function automatic int t_db(input int n_dc);
    return 1 << (n_dc - 2);
  endfunction

  // Hold time before auto-repeat kicks in.
  function automatic int t_hold(input int n_dc);
    return 1 << n_dc;
  endfunction

  // Auto-repeat period while held.
  function automatic int t_rpt(input int n_dc);
    return 1 << (n_dc - 2);
  endfunction

  // Output decode for a given state; registered by the top.
  function automatic pb_out_t decode_out(input state_e s);
    pb_out_t o;
    o.dpb  = (s == SCEN_ST) || (s == WH) || (s == MCEN_ST) || (s == CCR) || (s == WFCR);
    o.scen = (s == SCEN_ST);
    o.mcen = (s == SCEN_ST) || (s == MCEN_ST);
    o.ccen = (s == SCEN_ST) || (s == MCEN_ST) || (s == CCR);
    return o;
  endfunction

endpackage

// File: rtl/ee201_pb_debouncer_pb_sync.sv
// Two-flop synchronizer for the raw asynchronous button input.
module ee201_pb_debouncer_pb_sync (
  input  logic clk,
  input  logic resetbtn,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the raw level through two flops; both clear on reset.
  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/ee201_pb_debouncer.sv
// Push-button debouncer with single-shot, auto-repeat and continuous enables.
// Define EE201_PB_SYNC_EN to put a 2-flop synchronizer in front of the FSM
// (adds 2 cycles to every latency); otherwise pb must already be synchronous.
module ee201_pb_debouncer
  import ee201_pb_debouncer_pkg::*;
#(
  parameter int N_dc = 25
) (
  input  logic clk,
  input  logic resetbtn,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen
);

  // Terminal counts: a window of T cycles ends when the counter reads T-1.
  localparam int DB_LAST_I   = t_db(N_dc) - 1;
  localparam int HOLD_LAST_I = t_hold(N_dc) - 1;
  localparam int RPT_LAST_I  = t_rpt(N_dc) - 1;
  localparam logic [N_dc-1:0] DB_LAST   = DB_LAST_I[N_dc-1:0];
  localparam logic [N_dc-1:0] HOLD_LAST = HOLD_LAST_I[N_dc-1:0];
  localparam logic [N_dc-1:0] RPT_LAST  = RPT_LAST_I[N_dc-1:0];

  logic            pb_s;
  state_e          state_q, state_d;
  logic [N_dc-1:0] cnt_q, cnt_d, cnt_inc;
  pb_out_t         out_q, out_d;

`ifdef EE201_PB_SYNC_EN
  ee201_pb_debouncer_pb_sync u_pb_sync (
    .clk      (clk),
    .resetbtn (resetbtn),
    .d_i      (pb),
    .q_o      (pb_s)
  );
`else
  assign pb_s = pb;
`endif

  // Saturate rather than wrap so a stalled state can never alias a window end.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Next-state logic; the counter restarts on every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INI:     if (pb_s) state_d = WQ;
      WQ:      if (!pb_s)                 state_d = INI;
               else if (cnt_q == DB_LAST) state_d = SCEN_ST;
      SCEN_ST:                            state_d = WH;
      WH:      if (!pb_s)                 state_d = WFCR;
               else if (cnt_q == HOLD_LAST) state_d = MCEN_ST;
      MCEN_ST:                            state_d = CCR;
      CCR:     if (!pb_s)                 state_d = WFCR;
               else if (cnt_q == RPT_LAST) state_d = MCEN_ST;
      WFCR:    if (pb_s)                  state_d = WH;
               else if (cnt_q == DB_LAST) state_d = INI;
      default:                            state_d = INI;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;
    out_d = decode_out(state_d);
  end

  // State, counter and registered outputs; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge resetbtn) begin
    if (resetbtn) begin
      state_q <= INI;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign dpb  = out_q.dpb;
  assign scen = out_q.scen;
  assign mcen = out_q.mcen;
  assign ccen = out_q.ccen;

endmodule

// File: tb/tb_ee201_pb_debouncer.sv
// Directed bench for the debouncer at N_dc=6 (T_DB=16, T_HOLD=64, T_RPT=16),
// default build without the input synchronizer.
module tb_ee201_pb_debouncer;

  logic clk = 1'b0;
  logic resetbtn;
  logic pb;
  logic dpb, scen, mcen, ccen;

  int total = 0;
  int bad   = 0;
  int nscen = 0;
  int tcyc  = 0;

  typedef struct {
    bit         pb;
    int         len;
    logic [3:0] exp;   // {dpb, scen, mcen, ccen}
  } seg_t;

  seg_t segs[$];

  ee201_pb_debouncer #(.N_dc(6)) dut (
    .clk      (clk),
    .resetbtn (resetbtn),
    .pb       (pb),
    .dpb      (dpb),
    .scen     (scen),
    .mcen     (mcen),
    .ccen     (ccen)
  );

  always #5 clk = ~clk;

  function automatic void add(input bit p, input int n, input logic [3:0] e);
    seg_t s;
    s.pb  = p;
    s.len = n;
    s.exp = e;
    segs.push_back(s);
  endfunction

  task automatic check_now(input string name, input logic [3:0] e);
    logic [3:0] got;
    got = {dpb, scen, mcen, ccen};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got dpb/scen/mcen/ccen=%b want %b", name, tcyc, got, e);
    end
  endtask

  // Drive one pb sample, clock it, then check outputs 1 time unit after the edge.
  task automatic step(input string name, input bit p, input logic [3:0] e);
    pb = p;
    @(posedge clk);
    #1;
    tcyc++;
    if (scen === 1'b1) nscen++;
    check_now(name, e);
  endtask

  task automatic run_segs(input string name);
    tcyc = 0;
    foreach (segs[i])
      for (int k = 0; k < segs[i].len; k++)
        step(name, segs[i].pb, segs[i].exp);
    segs.delete();
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  int s0;

  initial begin
    pb = 1'b0;
    resetbtn = 1'b1;
    #1;
    check_now("reset_state", 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_hold", 4'b0000);
    resetbtn = 1'b0;

    add(0, 4, 4'b0000);
    run_segs("idle");

    // Clean press: pulse at 17, dpb until 16 cycles after release.
    s0 = nscen;
    add(1, 16, 4'b0000);
    add(1,  1, 4'b1111);
    add(1, 23, 4'b1000);
    add(0, 16, 4'b1000);
    add(0,  5, 4'b0000);
    run_segs("clean");
    check_int("clean_scen_count", nscen - s0, 1);

    // Bounce: 10 high / 3 low, five times, never qualifies.
    s0 = nscen;
    for (int r = 0; r < 5; r++) begin
      add(1, 10, 4'b0000);
      add(0,  3, 4'b0000);
    end
    add(0, 4, 4'b0000);
    run_segs("bounce");
    check_int("bounce_scen_count", nscen - s0, 0);

    // Long hold: mcen at 17, 82 and every 17 after; ccen continuous from 82.
    add(1, 16, 4'b0000);
    add(1,  1, 4'b1111);
    add(1, 64, 4'b1000);
    add(1,  1, 4'b1011);
    for (int r = 0; r < 6; r++) begin
      add(1, 16, 4'b1001);
      add(1,  1, 4'b1011);
    end
    add(1, 16, 4'b1001);
    add(0, 16, 4'b1000);
    add(0,  4, 4'b0000);
    run_segs("long_hold");

    // Release bounce: dpb holds through the glitch, one scen only.
    s0 = nscen;
    add(1, 16, 4'b0000);
    add(1,  1, 4'b1111);
    add(1,  5, 4'b1000);
    add(0,  5, 4'b1000);
    add(1,  2, 4'b1000);
    add(0, 16, 4'b1000);
    add(0,  4, 4'b0000);
    run_segs("rel_bounce");
    check_int("rel_bounce_scen_count", nscen - s0, 1);

    // Reset while in WH: outputs drop immediately, held button re-qualifies.
    add(1, 16, 4'b0000);
    add(1,  1, 4'b1111);
    add(1, 10, 4'b1000);
    run_segs("pre_reset");
    #2;
    resetbtn = 1'b1;
    #1;
    check_now("reset_mid_wh", 4'b0000);
    @(posedge clk);
    #1;
    check_now("reset_mid_wh_hold", 4'b0000);
    resetbtn = 1'b0;
    s0 = nscen;
    add(1, 16, 4'b0000);
    add(1,  1, 4'b1111);
    add(1,  3, 4'b1000);
    add(0, 16, 4'b1000);
    add(0,  3, 4'b0000);
    run_segs("post_reset");
    check_int("post_reset_scen_count", nscen - s0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
